// File: rtl/antares_pipe_stage.sv
// antares_pipe_stage: elastic valid/ready pipeline register for the Antares pipeline.
// Main entry M drives the outputs directly. With SKID=1 a skid entry S absorbs
// one item while M stalls, so in_ready comes straight from a flop. With SKID=0
// only M exists and in_ready is combinational.
// Data bits are held across bubbles. Control bits are cleared in every invalid
// slot, so no write enable or trap can leak out of a bubble.
// Optional macro ANTARES_PIPE_STATS_EN builds a saturating stall-cycle counter.
// Without the macro, stall_count is tied to zero.
module antares_pipe_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_count
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic              m_load;
    logic              accept;

    // M can take a new item when it is empty or its item leaves this cycle.
    assign m_load = ~m_valid | out_ready;
    assign accept = in_valid & in_ready;

    generate
        if (SKID != 0) begin : g_skid
            // S full means two items are held, so refuse input.
            assign in_ready = ~s_valid;

            // Skid entry: catches an accepted item while M stalls, and empties when M reloads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_valid <= 1'b0;
                    s_data  <= '0;
                    s_ctrl  <= '0;
                end else if (flush) begin
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                end else if (m_load) begin
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                end else if (accept) begin
                    s_valid <= 1'b1;
                    s_data  <= in_data;
                    s_ctrl  <= in_ctrl;
                end
            end
        end else begin : g_noskid
            assign in_ready = m_load;
            assign s_valid  = 1'b0;
            assign s_data   = '0;
            assign s_ctrl   = '0;
        end
    endgenerate

    // Main entry: S drains first to keep FIFO order. Otherwise take the input, or become a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end else if (m_load) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_ctrl  <= s_ctrl;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
            end else begin
                m_valid <= 1'b0;
                m_ctrl  <= '0;
            end
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

`ifdef ANTARES_PIPE_STATS_EN
    logic [15:0] stall_q;

    // Count cycles where a real item is blocked downstream. Saturate rather than wrap; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (m_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_antares_pipe_stage.sv
// Testbench for antares_pipe_stage. Instances with SKID=1 and SKID=0 receive the same stimulus.
// Each instance is compared against a FIFO-queue reference model.
// The expected stall count follows ANTARES_PIPE_STATS_EN.
module tb_antares_pipe_stage;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1;
    logic [63:0] out_data1;
    logic [7:0]  out_ctrl1;
    logic [1:0]  occ1;
    logic [15:0] stall1;

    logic        in_ready0, out_valid0;
    logic [63:0] out_data0;
    logic [7:0]  out_ctrl0;
    logic [1:0]  occ0;
    logic [15:0] stall0;

    int total = 0;
    int bad = 0;

    item_t q1[$];
    item_t q0[$];
    int    sc1 = 0;
    int    sc0 = 0;

    always #5 clk = ~clk;

    antares_pipe_stage #(.DATA_W(64), .CTRL_W(8), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .occupancy(occ1), .stall_count(stall1)
    );

    antares_pipe_stage #(.DATA_W(64), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occ0), .stall_count(stall0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_stall(input int sc);
`ifdef ANTARES_PIPE_STATS_EN
        return 16'(sc);
`else
        return 16'h0000;
`endif
    endfunction

    // Compare both instances with the model, then advance the model using the current inputs.
    task automatic compare_and_advance();
        logic rdy1, rdy0, acc1, acc0, cons1, cons0;
        item_t it;
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || out_ready;

        check("s1_out_valid", 64'(out_valid1), 64'(q1.size() > 0));
        if (q1.size() > 0) begin
            check("s1_out_data", out_data1, q1[0].d);
            check("s1_out_ctrl", 64'(out_ctrl1), 64'(q1[0].c));
        end else begin
            check("s1_bubble_ctrl", 64'(out_ctrl1), 64'h0);
        end
        check("s1_in_ready", 64'(in_ready1), 64'(rdy1));
        check("s1_occupancy", 64'(occ1), 64'(q1.size()));
        check("s1_stall_count", 64'(stall1), 64'(exp_stall(sc1)));

        check("s0_out_valid", 64'(out_valid0), 64'(q0.size() > 0));
        if (q0.size() > 0) begin
            check("s0_out_data", out_data0, q0[0].d);
            check("s0_out_ctrl", 64'(out_ctrl0), 64'(q0[0].c));
        end else begin
            check("s0_bubble_ctrl", 64'(out_ctrl0), 64'h0);
        end
        check("s0_in_ready", 64'(in_ready0), 64'(rdy0));
        check("s0_occupancy", 64'(occ0), 64'(q0.size()));
        check("s0_stall_count", 64'(stall0), 64'(exp_stall(sc0)));

        acc1  = in_valid && rdy1;
        acc0  = in_valid && rdy0;
        cons1 = (q1.size() > 0) && out_ready;
        cons0 = (q0.size() > 0) && out_ready;
        if ((q1.size() > 0) && !out_ready && sc1 < 65535) sc1++;
        if ((q0.size() > 0) && !out_ready && sc0 < 65535) sc0++;
        it.d = in_data;
        it.c = in_ctrl;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (cons1) void'(q1.pop_front());
            if (acc1) q1.push_back(it);
            if (cons0) void'(q0.pop_front());
            if (acc0) q0.push_back(it);
        end
    endtask

    task automatic step(input logic iv, input logic [63:0] id, input logic [7:0] ic,
                        input logic fl, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        in_ctrl   = ic;
        flush     = fl;
        out_ready = ordy;
        #1;
        compare_and_advance();
    endtask

    initial begin
        // Check outputs while reset is held.
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid1), 64'h0);
        check("rst_out_data", out_data1, 64'h0);
        check("rst_out_ctrl", 64'(out_ctrl1), 64'h0);
        check("rst_in_ready", 64'(in_ready1), 64'h1);
        check("rst_occupancy", 64'(occ1), 64'h0);
        check("rst_stall", 64'(stall1), 64'h0);
        check("rst0_out_valid", 64'(out_valid0), 64'h0);
        check("rst0_in_ready", 64'(in_ready0), 64'h1);
        rst = 1'b0;

        // Idle inputs after reset release.
        step(0, 64'h0, 8'h0, 0, 0);
        step(0, 64'h0, 8'h0, 0, 1);

        // Stream 1..4 at full throughput.
        for (int i = 1; i <= 4; i++) step(1, 64'(i), 8'(i), 0, 1);
        step(0, 64'h0, 8'h0, 0, 1);
        step(0, 64'h0, 8'h0, 0, 1);

        // Fill the stage with A and B while downstream stalls, then drain.
        step(1, 64'hA, 8'hFF, 0, 0);
        step(1, 64'hB, 8'hFF, 0, 0);
        step(1, 64'hC, 8'h11, 0, 0);
        step(0, 64'h0, 8'h0, 0, 0);
        step(0, 64'h0, 8'h0, 0, 1);
        step(0, 64'h0, 8'h0, 0, 1);
        step(0, 64'h0, 8'h0, 0, 1);

        // Flush a full stage with a concurrent input; the input must be discarded.
        step(1, 64'hA, 8'hFF, 0, 0);
        step(1, 64'hB, 8'hFF, 0, 0);
        step(1, 64'hDEAD, 8'hFF, 1, 0);
        step(0, 64'h0, 8'h0, 0, 0);
        step(0, 64'h0, 8'h0, 0, 1);

        // Accept and consume together while one item is held.
        step(1, 64'h21, 8'h01, 0, 1);
        step(1, 64'h22, 8'h02, 0, 1);
        step(1, 64'h23, 8'h03, 0, 1);
        step(0, 64'h0, 8'h0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        // Assert reset mid-stall while the stage is full. All entries must drop at once.
        step(1, 64'h31, 8'hFF, 0, 0);
        step(1, 64'h32, 8'hFF, 0, 0);
        step(0, 64'h0, 8'h0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid1), 64'h0);
        check("arst_out_ctrl", 64'(out_ctrl1), 64'h0);
        check("arst_occupancy", 64'(occ1), 64'h0);
        check("arst_in_ready", 64'(in_ready1), 64'h1);
        check("arst_stall", 64'(stall1), 64'h0);
        check("arst0_out_valid", 64'(out_valid0), 64'h0);
        q1.delete();
        q0.delete();
        sc1 = 0;
        sc0 = 0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Long stall to reach stall-counter saturation.
        step(1, 64'h55, 8'h5A, 0, 0);
        for (int i = 0; i < 70000; i++) step(0, 64'h0, 8'h0, 0, 0);
        step(0, 64'h0, 8'h0, 0, 0);
        step(0, 64'h0, 8'h0, 1, 0);
        step(0, 64'h0, 8'h0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/antares_pipe_stage.md
Name: antares_pipe_stage

Overview:
Parametrised, elastic pipeline register for the Antares pipeline. It is the generalised successor of the fixed EX->MEM stage register.
- Replaces ad-hoc stall/flush muxing with a valid/ready handshake and an optional skid entry, so upstream ready is fully registered.
- Payload is split in two. Data bits are held or propagated. Control bits (write enables, trap, exception source) are forced to zero whenever the slot holds a bubble.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 64, width of payload that is propagated without clearing (ALU result, store data, PC, ...)
CTRL_W, 8, width of control payload; zeroed in any non-valid slot
SKID, 1, 1 = two-entry elastic stage with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  main clock
rst  in  1  main reset
in_valid  in  1  upstream stage holds a real instruction
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
flush  in  1  kill all held entries (exception/branch redirect)
out_valid  out  1  downstream slot holds a real instruction
out_ready  in  1  downstream consumes this cycle
out_data  out  DATA_W  registered data payload
out_ctrl  out  CTRL_W  registered control payload, zero when out_valid=0
occupancy  out  2  entries held (0..2; max 1 when SKID=0)
stall_count  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. During reset and on release: main entry M and skid entry S invalid; out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_count=0; in_ready=1.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - out_valid/out_data/out_ctrl come straight from M (registered).
- M update: M loads when ~M.valid or out_ready.
  - Source is S if S.valid, else the input.
  - If nothing is accepted and S is empty, M becomes a bubble: valid=0, ctrl=0, data held.
- SKID=1:
  - in_ready = ~S.valid (registered).
  - An input accepted while M is valid and out_ready=0 is written into S.
  - S drains into M on the next cycle M loads.
  - Ordering is strictly FIFO.
- SKID=0:
  - S does not exist.
  - in_ready = ~M.valid | out_ready (combinational).
- Latency and throughput:
  - Empty stage: accepted item appears at out_valid the next cycle.
  - Sustained throughput: 1 item/cycle with out_ready held high.
- Stall: with out_ready=0, M is frozen. Data and ctrl are held bit-exact.
- Flush (synchronous, priority over all but rst):
  - Next cycle M.valid=0, S.valid=0, out_ctrl=0, occupancy=0.
  - Data registers are held.
  - An accept in the flush cycle is discarded.
  - in_ready is 1 the following cycle.
- Control clearing: out_ctrl is exactly zero in every cycle out_valid=0. No write enable or trap can leak from a bubble.
- Occupancy:
  - occupancy = M.valid + S.valid.
  - Never exceeds 2.
  - With SKID=1, in_ready=0 exactly when occupancy=2.
- Simultaneous accept and consume at occupancy=1: occupancy stays 1 and the new item lands in M.
- Reset asserted mid-stall: all entries drop immediately and asynchronously. No partial item survives.

Optional Feature:
Macro ANTARES_PIPE_STATS_EN.
- Defined: stall_count increments by 1 on every cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF with no wrap.
  - Cleared by rst only; flush does not clear it.
- Undefined: stall_count is tied to 16'h0000 and no counter logic is built. The port list is identical in both builds.

Test Plan:
- Reset release, idle inputs -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
- SKID=1, in_valid=1 with data 0x1..0x4 on consecutive cycles, out_ready=1 -> out_data 0x1..0x4 one cycle later each; in_ready stays 1.
- SKID=1, accept 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB in order, in_ready returns to 1.
- Full stage (0xA in M, 0xB in S, ctrl=8'hFF) with flush=1 and concurrent in_valid -> next cycle out_valid=0, out_ctrl=8'h00, occupancy=0; input item never appears.
- SKID=0, M valid, out_ready=1, in_valid=1 same cycle -> in_ready=1 combinationally, new item in M next cycle, occupancy stays 1.
- ANTARES_PIPE_STATS_EN defined, out_valid=1 with out_ready=0 for 70000 cycles -> stall_count=16'hFFFF. Undefined -> stall_count=0 throughout.
